// File: rtl/ballot_input_ctrl.sv
// ballot_input_ctrl: debounces four candidate buttons and issues one vote strobe per armed ballot
module ballot_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       next_voter,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
  input  logic       btn4,
  output logic       voted_candidate1,
  output logic       voted_candidate2,
  output logic       voted_candidate3,
  output logic       voted_candidate4,
  output logic       ready,
  output logic       invalid,
  output logic [7:0] ballots_cast
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ARMED, VOTE, WAIT_REL} state_t;
  state_t state, state_n;
  logic [3:0] raw, s1, sync_q, stable, voted;
  logic [2:0] pc;
  logic [1:0] idx, sel;
  logic ret, armed_live;
  assign raw = {btn4, btn3, btn2, btn1};
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= '0;
      sync_q <= '0;
    end else begin
      s1 <= raw;
      sync_q <= s1;
    end
  for (genvar i = 0; i < 4; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic st;
    always_ff @(posedge clk)
      if (rst) begin
        st <= 1'b0;
        cnt <= '0;
      end else if (sync_q[i] == st) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        st <= sync_q[i];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    assign stable[i] = st;
  end
  assign pc = {2'b0, stable[0]} + {2'b0, stable[1]} + {2'b0, stable[2]} + {2'b0, stable[3]};
  assign sel = stable[1] ? 2'd1 : stable[2] ? 2'd2 : stable[3] ? 2'd3 : 2'd0;
  // mode is sampled here, so a press evaluated on the same edge mode rises is held off
  assign armed_live = (state == ARMED) && !mode;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (next_voter && stable == 4'b0) state_n = ARMED;
      ARMED:    if (!mode && pc != 3'd0) state_n = pc == 3'd1 ? VOTE : WAIT_REL;
      VOTE:     state_n = WAIT_REL;
      WAIT_REL: if (stable == 4'b0) state_n = ret ? ARMED : IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      idx <= '0;
      ret <= 1'b0;
      invalid <= 1'b0;
      ballots_cast <= '0;
    end else begin
      idx <= (armed_live && pc == 3'd1) ? sel : idx;
      ret <= (armed_live && pc > 3'd1) ? 1'b1 : (state == VOTE) ? 1'b0 : ret;
      invalid <= armed_live && pc > 3'd1;
      ballots_cast <= ballots_cast + {7'b0, state == VOTE};
    end
  always_comb begin
    voted = (state == VOTE) ? 4'(1) << idx : 4'b0;
    ready = state == ARMED;
  end
  assign {voted_candidate4, voted_candidate3, voted_candidate2, voted_candidate1} = voted;
endmodule

// File: tb/tb_ballot_input_ctrl.sv
// tb_ballot_input_ctrl: scenario tasks with a strobe scoreboard for ballot_input_ctrl
module tb_ballot_input_ctrl;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst, mode, next_voter, btn1, btn2, btn3, btn4;
  logic voted_candidate1, voted_candidate2, voted_candidate3, voted_candidate4;
  logic ready, invalid;
  logic [7:0] ballots_cast;
  logic [3:0] vs;
  int n_cmp = 0, n_err = 0, exp_count = 0, e_mon;
  int exp_q[$];
  bit mon_en = 0;

  ballot_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .mode(mode), .next_voter(next_voter),
    .btn1(btn1), .btn2(btn2), .btn3(btn3), .btn4(btn4),
    .voted_candidate1(voted_candidate1), .voted_candidate2(voted_candidate2),
    .voted_candidate3(voted_candidate3), .voted_candidate4(voted_candidate4),
    .ready(ready), .invalid(invalid), .ballots_cast(ballots_cast)
  );

  always #5 clk = ~clk;
  assign vs = {voted_candidate4, voted_candidate3, voted_candidate2, voted_candidate1};

  always @(negedge clk)
    if (mon_en && vs != 4'b0) begin
      n_cmp++;
      if ($countones(vs) != 1) begin
        n_err++;
        $display("FAIL onehot: strobes=%b required exactly one", vs);
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: strobes=%b required none", vs);
      end else begin
        e_mon = exp_q.pop_front();
        if (vs !== 4'(1 << (e_mon - 1))) begin
          n_err++;
          $display("FAIL strobe_id: strobes=%b required candidate %0d", vs, e_mon);
        end
      end
    end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(int b, logic v);
    case (b)
      1: btn1 = v;
      2: btn2 = v;
      3: btn3 = v;
      default: btn4 = v;
    endcase
  endtask

  task automatic do_reset();
    rst = 1; mode = 0; next_voter = 0;
    btn1 = 0; btn2 = 0; btn3 = 0; btn4 = 0;
    tick(2);
    rst = 0;
    exp_q.delete();
    exp_count = 0;
  endtask

  task automatic arm();
    next_voter = 1;
    tick(1);
    next_voter = 0;
  endtask

  task automatic vote(int b);
    set_btn(b, 1);
    exp_q.push_back(b);
    exp_count++;
    tick(D + 8);
    set_btn(b, 0);
    tick(D + 4);
  endtask

  task automatic test_reset();
    do_reset();
    mon_en = 1;
    n_cmp++;
    if ({vs, ready, invalid} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required 000000", {vs, ready, invalid});
    end
    n_cmp++;
    if (ballots_cast !== 8'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d required 0", ballots_cast);
    end
  endtask

  task automatic test_basic();
    do_reset();
    arm();
    n_cmp++;
    if (ready !== 1'b1) begin n_err++; $display("FAIL arm_ready: got %b required 1", ready); end
    btn2 = 1;
    exp_q.push_back(2);
    exp_count++;
    tick(1);
    tick(D + 1);
    n_cmp++;
    if (vs !== 4'b0) begin n_err++; $display("FAIL early_strobe: got %b required 0000", vs); end
    tick(1);
    n_cmp++;
    if (vs !== 4'b0010 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL vote_timing: strobes=%b ready=%b required 0010 0", vs, ready);
    end
    tick(1);
    n_cmp++;
    if (vs !== 4'b0 || ballots_cast !== 8'(exp_count)) begin
      n_err++;
      $display("FAIL after_vote: strobes=%b count=%0d required 0000 %0d", vs, ballots_cast, exp_count);
    end
    tick(13);
    btn2 = 0;
    tick(D + 4);
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL rearm_after_release: ready=%b required 0", ready); end
    arm();
    n_cmp++;
    if (ready !== 1'b1) begin n_err++; $display("FAIL back_to_idle: ready=%b required 1", ready); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 30; i++) begin
      btn1 = i[1];
      tick(1);
    end
    btn1 = 0;
    tick(D + 4);
    n_cmp++;
    if (ready !== 1'b1 || ballots_cast !== 8'(exp_count)) begin
      n_err++;
      $display("FAIL bounce: ready=%b count=%0d required 1 %0d", ready, ballots_cast, exp_count);
    end
    vote(1);
    n_cmp++;
    if (exp_q.size() != 0 || ballots_cast !== 8'(exp_count)) begin
      n_err++;
      $display("FAIL clean_press: pending=%0d count=%0d required 0 %0d", exp_q.size(), ballots_cast, exp_count);
    end
  endtask

  task automatic test_multi();
    int c = 0, first = -1;
    arm();
    btn3 = 1; btn4 = 1;
    for (int i = 0; i < 2 * D + 6; i++) begin
      tick(1);
      if (invalid === 1'b1) begin
        c++;
        if (first < 0) first = i;
      end
    end
    n_cmp++;
    if (c != 1 || first != D + 2) begin
      n_err++;
      $display("FAIL invalid_pulse: count=%0d edge=%0d required 1 %0d", c, first, D + 2);
    end
    btn3 = 0; btn4 = 0;
    tick(D + 4);
    n_cmp++;
    if (ready !== 1'b1 || ballots_cast !== 8'(exp_count)) begin
      n_err++;
      $display("FAIL multi_return: ready=%b count=%0d required 1 %0d", ready, ballots_cast, exp_count);
    end
    vote(4);
    n_cmp++;
    if (exp_q.size() != 0 || ballots_cast !== 8'(exp_count)) begin
      n_err++;
      $display("FAIL multi_then_vote: pending=%0d count=%0d required 0 %0d", exp_q.size(), ballots_cast, exp_count);
    end
  endtask

  task automatic test_lockout();
    arm();
    btn1 = 1;
    exp_q.push_back(1);
    exp_count++;
    tick(D + 8);
    next_voter = 1;
    tick(3);
    next_voter = 0;
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL lockout_held: ready=%b required 0", ready); end
    btn1 = 0;
    tick(D + 4);
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL lockout_released: ready=%b required 0", ready); end
    arm();
    n_cmp++;
    if (ready !== 1'b1) begin n_err++; $display("FAIL lockout_rearm: ready=%b required 1", ready); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) begin
      arm();
      vote(i % 4 + 1);
    end
    n_cmp++;
    if (ballots_cast !== 8'd255) begin n_err++; $display("FAIL count_255: got %0d required 255", ballots_cast); end
    arm();
    vote(2);
    n_cmp++;
    if (ballots_cast !== 8'(exp_count) || ballots_cast !== 8'd0) begin
      n_err++;
      $display("FAIL count_wrap: got %0d required 0", ballots_cast);
    end
  endtask

  task automatic test_mode_reset();
    do_reset();
    arm();
    mode = 1;
    btn1 = 1;
    tick(D + 8);
    n_cmp++;
    if (ready !== 1'b1 || ballots_cast !== 8'd0) begin
      n_err++;
      $display("FAIL display_mode: ready=%b count=%0d required 1 0", ready, ballots_cast);
    end
    btn1 = 0;
    tick(D + 4);
    mode = 0;
    btn2 = 1;
    exp_q.push_back(2);
    exp_count++;
    tick(1);
    tick(D + 2);
    n_cmp++;
    if (vs !== 4'b0010) begin n_err++; $display("FAIL vote_before_rst: got %b required 0010", vs); end
    rst = 1;
    tick(1);
    n_cmp++;
    if ({vs, ready, invalid} !== 6'b0 || ballots_cast !== 8'd0) begin
      n_err++;
      $display("FAIL rst_in_vote: outs=%b count=%0d required 000000 0", {vs, ready, invalid}, ballots_cast);
    end
    btn2 = 0;
    tick(2);
    rst = 0;
    exp_count = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_multi();
    test_lockout();
    test_wrap();
    test_mode_reset();
    tick(4);
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL missing_strobes: pending=%0d required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ballot_input_ctrl.md
# ballot_input_ctrl

Front-end stage of the voting machine: turns four raw, bouncing candidate push-buttons into clean single-cycle vote strobes for the vote counter. Each voter gets one vote only. A polling officer arms the booth with `next_voter`. The block accepts exactly one valid single-button press, emits one strobe, then locks out until all buttons are released and the booth is re-armed. Strobes are registered and last exactly one `clk` cycle, so the downstream counter increments once per ballot.

## Interface
- `DEBOUNCE_CYCLES`, default 20: consecutive cycles a synchronized level must persist before it is accepted; legal range 2..65535.
- `clk`  input  1  system clock.
- `rst`  input  1  reset: synchronous, active-high. Clock is `clk`.
- `mode`  input  1  0 = voting, 1 = display; votes are not issued while 1.
- `next_voter`  input  1  officer arm request, level sampled per cycle.
- `btn1`..`btn4`  input  1 each  raw asynchronous candidate buttons, active-high.
- `voted_candidate1`..`voted_candidate4`  output  1 each  one-cycle vote strobe.
- `ready`  output  1  booth armed and waiting for a press (state ARMED).
- `invalid`  output  1  one-cycle pulse on a multi-button press.
- `ballots_cast`  output  8  count of strobes issued; wraps 255→0.

## Operation
- **Synchronizer:** each button has two flops, reset to 0. `sync_q` is the second flop.
- **Debouncer, per button:**
  - `stable` flag, reset 0, plus a counter of width ceil(log2(DEBOUNCE_CYCLES+1)), reset 0.
  - Each edge where `sync_q != stable`, the counter increments. When the counter == DEBOUNCE_CYCLES-1 at such an edge, `stable <= sync_q` and the counter clears.
  - Any edge where `sync_q == stable` clears the counter, so bounces shorter than DEBOUNCE_CYCLES are rejected.
- **State machine:** states IDLE, ARMED, VOTE, WAIT_REL; reset state IDLE.
  - **IDLE:** goes to ARMED when `next_voter`=1 and all four `stable`=0. Otherwise stays in IDLE, and button activity is ignored.
  - **ARMED:** let popcount = number of set `stable` bits.
    - `mode`=1: hold, ignore presses.
    - popcount==1: go to VOTE and latch the candidate index.
    - popcount≥2: pulse `invalid`, go to WAIT_REL with the return flag set to ARMED. The ballot is not consumed.
    - popcount==0: stay.
  - **VOTE:** lasts one cycle.
    - The selected `voted_candidateN`=1 and `ballots_cast` increments.
    - Then go to WAIT_REL with the return flag set to IDLE.
  - **WAIT_REL:** stays until all `stable`=0, then goes to the return-flag state.
- `next_voter` is ignored outside IDLE. Holding it high does not grant a second vote until WAIT_REL completes and IDLE is re-entered.
- Output decode:
  - `voted_candidateN` = (state==VOTE) & (index==N).
  - `ready` = (state==ARMED).
  - `invalid` is registered.
- At most one `voted_candidate` is high in any cycle.

## Timing
- **Reset values:** all outputs 0, `ballots_cast`=0, state IDLE, sync flops, `stable` flags and counters 0.
- `rst` mid-operation, including during VOTE, aborts immediately. No strobe is emitted in the cycle after the reset edge.
- **Press latency:** D = DEBOUNCE_CYCLES. Edge 0 is the first edge sampling the new raw high level, with the booth in ARMED and the level then held.
  - `sync_q`=1 after edge 1.
  - `stable`=1 after edge D+1.
  - State VOTE, and therefore the strobe, is high from edge D+2 to edge D+3.
- **Release latency:** `stable` falls D+1 edges after the raw release is first sampled. WAIT_REL exits on the following edge.
- IDLE→ARMED takes 1 edge after `next_voter` is sampled with all buttons released.
- Two buttons whose `stable` rises on the same edge count as a multi-press: `invalid` is high for one cycle D+2 edges after sampling.
- A second button stabilising after the first has already moved ARMED→VOTE is ignored. The vote goes to the first button.
- A `mode` 0→1 change on the same edge ARMED evaluates a single press: `mode` is sampled by the state machine, so no vote is issued.
- `ballots_cast` at 255 plus one vote gives 0.

## Test plan
- **Basic vote:** DEBOUNCE_CYCLES=4; reset; `next_voter` pulse; `btn2` high clean for 20 cycles, then low.
  - `voted_candidate2` high for exactly 1 cycle, 6 edges after first sampling.
  - `ballots_cast`=1, `ready` drops, state returns to IDLE after release.
- **Bounce rejection:** `btn1` toggles every 2 cycles for 30 cycles, then goes low → no strobe, `ready` stays 1. Then a clean press → one `voted_candidate1` strobe.
- **Multi-press:** `btn3` and `btn4` pressed on the same cycle → `invalid` pulse once, no strobe. After release the block is back in ARMED (`ready`=1); then `btn4` alone → one `voted_candidate4` strobe.
- **Lockout:** after a vote, hold `btn1` and pulse `next_voter` → no re-arm. Release, then `next_voter` → `ready`=1. Repeat 256 ballots → `ballots_cast` wraps to 0.
- **Mode and reset:** with `mode`=1 in ARMED, press `btn1` → no strobe, `ready` stays 1. Assert `rst` in the same cycle as VOTE → all outputs 0 after that edge and `ballots_cast`=0.
